mem_bus_arbiter: RTL and testbench

//  Shares the single-port program/data memory between two masters: port 0 (uP core) and port 1 (loader/debug DMA).

---
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between two masters. Grants are registered and bursts are bounded.
// Define ARB_ROUND_ROBIN_EN for a round-robin tie-break in IDLE. Without it, port 0 has fixed priority.
module mem_bus_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt, cnt_inc;
  logic          last_owner, last_nxt;
  logic          xfer0, xfer1;
  logic          tie_pick1;
  logic          sel1;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_pick1 = ~last_owner;
`else
  assign tie_pick1 = 1'b0;
`endif

  assign gnt0  = (state == OWN0);
  assign gnt1  = (state == OWN1);
  assign xfer0 = req0 & gnt0;
  assign xfer1 = req1 & gnt1;

  // With no owner, the address/data mux parks on whichever port held the bus last.
  assign sel1        = gnt1 | ((state == IDLE) & last_owner);
  assign mem_address = sel1 ? addr1 : addr0;
  assign mem_wdata   = sel1 ? wdata1 : wdata0;
  assign mem_we      = (xfer0 & we0) | (xfer1 & we1);
  assign rdata       = mem_rdata;

  assign cnt_inc = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    last_nxt  = last_owner;
    case (state)
      IDLE: begin
        burst_nxt = '0;
        if (req0 && req1) state_nxt = tie_pick1 ? OWN1 : OWN0;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0) begin
          state_nxt = req1 ? OWN1 : IDLE;
          burst_nxt = '0;
        end else if (req1 && (cnt_inc == CW'(MAX_BURST))) begin
          state_nxt = OWN1;
          burst_nxt = '0;
        end else begin
          burst_nxt = cnt_inc;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_nxt = req0 ? OWN0 : IDLE;
          burst_nxt = '0;
        end else if (req0 && (cnt_inc == CW'(MAX_BURST))) begin
          state_nxt = OWN0;
          burst_nxt = '0;
        end else begin
          burst_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
    if ((state_nxt == OWN0) && (state != OWN0)) last_nxt = 1'b0;
    if ((state_nxt == OWN1) && (state != OWN1)) last_nxt = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      last_owner <= last_nxt;
      // The strobe follows the issuing port, even if ownership moves on this edge.
      rvalid0    <= xfer0 & ~we0;
      rvalid1    <= xfer1 & ~we1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: memory model plus a scoreboard of expected read returns.
module tb_mem_bus_arbiter;

  logic       clock, reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata, mem_address, mem_wdata, mem_rdata;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  typedef struct {
    bit         port;
    logic [7:0] data;
    int         due;
  } rd_t;
  rd_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_bus_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc_n <= cyc_n + 1;

  always @(posedge clock) begin
    if (mem_we) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    rd_t e;
    bit  exp_v;
    if (reset) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc_n);
      if (exp_v) begin
        e = sb.pop_front();
        chk("rvalid0", 32'(rvalid0), 32'(!e.port));
        chk("rvalid1", 32'(rvalid1), 32'(e.port));
        chk("rdata", 32'(rdata), 32'(e.data));
      end else if (rvalid0 || rvalid1) begin
        chk("spurious_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
      end
    end
  end

  // One bus cycle: drive inputs, check grants and the memory side, record expectations.
  task automatic cyc(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                     input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                     input logic eg0, input logic eg1, input string tag);
    logic t0, t1;
    rd_t  e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
    t0 = r0 & eg0;
    t1 = r1 & eg1;
    chk({tag, ".mem_we"}, 32'(mem_we), 32'((t0 & w0) | (t1 & w1)));
    if (t0 || t1) begin
      chk({tag, ".mem_address"}, 32'(mem_address), 32'(t0 ? a0 : a1));
      if (t0 ? w0 : w1) begin
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(t0 ? d0 : d1));
        ref_mem[t0 ? a0 : a1] = t0 ? d0 : d1;
      end else begin
        e.port = t1;
        e.data = ref_mem[t0 ? a0 : a1];
        e.due  = cyc_n + 1;
        sb.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[8'h10]     = 8'h2A;
    ref_mem[8'h10] = 8'h2A;

    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40; wdata1 = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.gnt0", 32'(gnt0), 32'(0));
    chk("rst.gnt1", 32'(gnt1), 32'(0));
    chk("rst.mem_we", 32'(mem_we), 32'(0));
    chk("rst.rvalid0", 32'(rvalid0), 32'(0));
    chk("rst.rvalid1", 32'(rvalid1), 32'(0));
    reset = 1'b1;

    // Both ports stream reads: 4 grants to port 0, 4 to port 1, 4 to port 0, with no gap.
    cyc(1, 0, 8'h00, 0, 1, 0, 8'h40, 0, 0, 0, "rel");
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 8'(i), 0, 1, 0, 8'(8'h40 + i), 0, ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, "burst");
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "drop");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

    cyc(1, 0, 8'h10, 0, 0, 0, 0, 0, 0, 0, "rd_req");
    cyc(1, 0, 8'h10, 0, 0, 0, 0, 0, 1, 0, "rd_gnt");
    chk("rd.rvalid0", 32'(rvalid0), 32'(1));
    chk("rd.rdata", 32'(rdata), 32'(8'h2A));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rd_rel");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rd_idle");

    cyc(0, 0, 0, 0, 1, 1, 8'h80, 8'h55, 0, 0, "wr_req");
    cyc(0, 0, 0, 0, 1, 1, 8'h80, 8'h55, 0, 1, "wr");
    cyc(0, 0, 0, 0, 1, 0, 8'h80, 8'h00, 0, 1, "rdback");
    chk("rdback.rvalid1", 32'(rvalid1), 32'(1));
    chk("rdback.rdata", 32'(rdata), 32'(8'h55));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "wr_rel");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wr_idle");

    // A lone requester keeps the bus past MAX_BURST; then a tie from IDLE.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 8'(8'h20 + i), 0, 0, 0, 0, 0, i > 0, 0, "lone");
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "lone_rel");
    cyc(1, 0, 8'h30, 0, 1, 0, 8'h31, 0, 0, 0, "tie_req");
    cyc(1, 0, 8'h30, 0, 1, 0, 8'h31, 0, !RR, RR, "tie");

    // Reset while a read return is pending: the strobe is dropped and the bus goes idle.
    reset = 1'b0;
    #1;
    chk("mid_rst.gnt0", 32'(gnt0), 32'(0));
    chk("mid_rst.gnt1", 32'(gnt1), 32'(0));
    chk("mid_rst.rvalid0", 32'(rvalid0), 32'(0));
    chk("mid_rst.rvalid1", 32'(rvalid1), 32'(0));
    chk("mid_rst.mem_we", 32'(mem_we), 32'(0));
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc(1, 0, 8'h05, 0, 1, 0, 8'h06, 0, 0, 0, "post_rst");
    cyc(1, 0, 8'h05, 0, 1, 0, 8'h06, 0, 1, 0, "post_rst_gnt");
    cyc(0, 0, 0, 0, 1, 0, 8'h07, 0, 1, 0, "handover");
    cyc(0, 0, 0, 0, 1, 0, 8'h07, 0, 0, 1, "handover_gnt");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "end_rel");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "end_idle");
    @(posedge clock);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
